// File: rtl/mat_pkg.sv
// Shared types for the MatCore inter-core vector switch: word/vector types,
// default geometry and the mailbox slot state encoding.
package mat_pkg;

    localparam int WORD_BITS        = 32;
    localparam int SWITCH_WIDTH     = 16;
    localparam int SWITCH_CORE_SIZE = 4;

    typedef logic [WORD_BITS-1:0]     mat_word_t;
    typedef mat_word_t [SWITCH_WIDTH-1:0] mat_vec_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/mat_switch_slot.sv
// One mailbox slot owned by a single source core: holds the posted vector and
// its destination until the addressed receiver drains it.
module mat_switch_slot
    import mat_pkg::*;
#(
    parameter int ADDR_BITS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 drain,
    input  logic [ADDR_BITS-1:0] load_dest,
    input  mat_vec_t             load_data,
    output logic                 full,
    output logic [ADDR_BITS-1:0] dest,
    output mat_vec_t             data
);

    slot_state_t state;

    // A load on the same edge as a drain refills the slot, so it stays FULL.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SLOT_EMPTY;
            dest  <= '0;
            data  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: if (load) state <= SLOT_FULL;
                SLOT_FULL:  if (drain && !load) state <= SLOT_EMPTY;
                default:    state <= SLOT_EMPTY;
            endcase
            if (load) begin
                dest <= load_dest;
                data <= load_data;
            end
        end
    end

    assign full = (state == SLOT_FULL);

endmodule

// File: rtl/mat_switch.sv
// Inter-core vector switch: each source posts one vector into its own slot,
// and the addressed destination pulls it by naming the source.
module mat_switch
    import mat_pkg::*;
#(
    parameter  int SWITCH_CORE_SIZE      = mat_pkg::SWITCH_CORE_SIZE,
    localparam int SWITCH_CORE_ADDR_SIZE = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                           send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] send_core_idx,
    input  mat_vec_t [SWITCH_CORE_SIZE-1:0]                       send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                           send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                           recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                           recv_ready,
    output mat_vec_t [SWITCH_CORE_SIZE-1:0]                       recv_data
);

    localparam int N = SWITCH_CORE_SIZE;
    localparam int A = SWITCH_CORE_ADDR_SIZE;

    logic [N-1:0]          slot_full;
    logic [N-1:0][A-1:0]   slot_dest;
    mat_vec_t [N-1:0]      slot_data;
    logic [N-1:0]          load;
    logic [N-1:0]          drain;
    logic [N-1:0]          match;

    function automatic logic idx_ok(input logic [A-1:0] idx);
        return {1'b0, idx} < (A+1)'(N);
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_slot
        mat_switch_slot #(
            .ADDR_BITS(A)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .load     (load[i]),
            .drain    (drain[i]),
            .load_dest(send_core_idx[i]),
            .load_data(send_data[i]),
            .full     (slot_full[i]),
            .dest     (slot_dest[i]),
            .data     (slot_data[i])
        );
    end

    // A slot names exactly one destination, so at most one receiver can drain it.
    always_comb begin
        match = '0;
        drain = '0;
        for (int j = 0; j < N; j++) begin
            if (recv_request[j] && !recv_ready[j] && idx_ok(recv_core_idx[j])) begin
                if (slot_full[recv_core_idx[j]] && (slot_dest[recv_core_idx[j]] == A'(j))) begin
                    match[j]                = 1'b1;
                    drain[recv_core_idx[j]] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < N; i++) begin
            load[i] = send_ready[i] && !send_ok[i] && idx_ok(send_core_idx[i])
                      && (!slot_full[i] || drain[i]);
        end
    end

    // The pulses block a second request in their own cycle, giving the turnaround.
    always_ff @(posedge clock) begin
        if (reset) begin
            send_ok    <= '0;
            recv_ready <= '0;
            recv_data  <= '0;
        end else begin
            send_ok    <= load;
            recv_ready <= match;
            for (int j = 0; j < N; j++) begin
                if (match[j]) begin
                    recv_data[j] <= slot_data[recv_core_idx[j]];
                end
            end
        end
    end

endmodule
